// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter
//   Shares one board LED among NUM_REQ status requesters. Requests are
//   served round-robin, and each owner keeps the LED for at least SLICE_MS
//   milliseconds while others wait. The LED is solid, off, or blinks slow or
//   fast, using a millisecond prescaler on the system clock.
//
// Ports
//   CLK    system clock
//   RST_N  synchronous, active-low reset
//   req    per-requester level-sensitive LED request
//   mode   per-requester mode, requester i at [2i+1:2i]
//          (00 off, 01 solid, 10 slow blink, 11 fast blink)
//   grant  one-hot current owner, all-zero when idle
//   led    registered LED drive, active-high
//   busy   high while any grant is active
//
// Optional feature macro: LED_ARB_PREEMPT_EN
//   When defined, requester 0 preempts any other owner and is never rotated
//   out by slice expiry.
module led_blink_arbiter #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int NUM_REQ  = 4,
  parameter int SLICE_MS = 2000,
  parameter int SLOW_HZ  = 2,
  parameter int FAST_HZ  = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   mode,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   led,
  output logic                   busy
);

  localparam int MS_DIV  = CLK_FREQ / 1000;
  localparam int PRE_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int HP_SLOW = 500 / SLOW_HZ;
  localparam int HP_FAST = 500 / FAST_HZ;
  localparam int HP_MAX  = (HP_SLOW > HP_FAST) ? HP_SLOW : HP_FAST;
  localparam int PH_W    = $clog2(HP_MAX + 1);
  localparam int SL_W    = $clog2(SLICE_MS + 1);
  localparam int IDX_W   = $clog2(NUM_REQ);

  localparam logic [PRE_W-1:0] PRE_TOP    = PRE_W'(MS_DIV - 1);
  localparam logic [PH_W-1:0]  HP_SLOW_M1 = PH_W'(HP_SLOW - 1);
  localparam logic [PH_W-1:0]  HP_FAST_M1 = PH_W'(HP_FAST - 1);
  localparam logic [SL_W-1:0]  SLICE_TOP  = SL_W'(SLICE_MS);
  localparam logic [IDX_W-1:0] RR_RESET   = IDX_W'(NUM_REQ - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  logic [0:0]         state_q,  state_d;
  logic [NUM_REQ-1:0] grant_q,  grant_d;
  logic [IDX_W-1:0]   rr_q,     rr_d;
  logic [SL_W-1:0]    slice_q,  slice_d;
  logic [PH_W-1:0]    ph_cnt_q, ph_cnt_d;
  logic               phase_q,  phase_d;
  logic               led_q,    led_d;
  logic [PRE_W-1:0]   pre_q,    pre_d;

  logic               ms_tick;
  logic               take;
  logic               new_grant;
  logic [IDX_W-1:0]   win;
  logic [NUM_REQ-1:0] cand;
  logic               owner_req;
  logic               slice_full;
  logic [1:0]         owner_mode;
  logic [PH_W-1:0]    hp_m1;

  // First requester set in cand strictly after ptr, wrapping; ptr itself is
  // considered last. Scanning farthest-first lets the nearest hit win.
  function automatic logic [IDX_W-1:0] pick_next(input logic [NUM_REQ-1:0] c,
                                                 input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0]   w;
    logic [NUM_REQ-1:0] sh;
    int                 idx;
    w = ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      sh  = c >> idx;
      if (sh[0]) w = IDX_W'(idx);
    end
    return w;
  endfunction

  function automatic logic [1:0] mode_of(input logic [2*NUM_REQ-1:0] m,
                                         input logic [IDX_W-1:0]     idx);
    logic [2*NUM_REQ-1:0] sh;
    sh = m >> (2 * int'(idx));
    return sh[1:0];
  endfunction

  function automatic logic led_level(input logic [1:0] m, input logic ph);
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      default: return ph;
    endcase
  endfunction

  always_comb begin
    ms_tick    = (pre_q == PRE_TOP);
    pre_d      = ms_tick ? '0 : pre_q + 1'b1;

    // In IDLE grant_q is zero, so cand is simply req.
    cand       = req & ~grant_q;
    owner_req  = |(req & grant_q);
    slice_full = (slice_q == SLICE_TOP);
    win        = pick_next(cand, rr_q);

    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    take       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) take = 1'b1;
      end
      default: begin
        // A drop wins over slice expiry; both pick the next waiter the same way.
        if (!owner_req) begin
          if (|cand) begin
            take = 1'b1;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
`ifdef LED_ARB_PREEMPT_EN
        end else if (slice_full && (|cand) && !grant_q[0]) begin
`else
        end else if (slice_full && (|cand)) begin
`endif
          take = 1'b1;
        end
`ifdef LED_ARB_PREEMPT_EN
        // Requester 0 takes the LED from any other owner immediately.
        if (req[0] && !grant_q[0]) begin
          take = 1'b1;
          win  = '0;
        end
`endif
      end
    endcase

    new_grant = take;
    if (take) begin
      state_d = ST_SHOW;
      grant_d = NUM_REQ'(1) << win;
      rr_d    = win;
    end

    if (new_grant) begin
      slice_d = '0;
    end else if (ms_tick && !slice_full) begin
      slice_d = slice_q + 1'b1;
    end else begin
      slice_d = slice_q;
    end

    // Half-period follows the owner's live mode; a counter left above a newly
    // shortened half-period toggles on the next tick.
    owner_mode = mode_of(mode, rr_q);
    hp_m1      = owner_mode[0] ? HP_FAST_M1 : HP_SLOW_M1;
    ph_cnt_d   = ph_cnt_q;
    phase_d    = phase_q;
    if (new_grant) begin
      ph_cnt_d = '0;
      phase_d  = 1'b1;
    end else if (ms_tick) begin
      if (ph_cnt_q >= hp_m1) begin
        ph_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        ph_cnt_d = ph_cnt_q + 1'b1;
      end
    end

    // Computed from next-state values so led lines up with grant and phase.
    if (grant_d == '0) begin
      led_d = 1'b0;
    end else begin
      led_d = led_level(mode_of(mode, rr_d), phase_d);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_q     <= RR_RESET;
      slice_q  <= '0;
      ph_cnt_q <= '0;
      phase_q  <= 1'b0;
      led_q    <= 1'b0;
      pre_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      slice_q  <= slice_d;
      ph_cnt_q <= ph_cnt_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
      pre_q    <= pre_d;
    end
  end

  assign grant = grant_q;
  assign led   = led_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Testbench for led_blink_arbiter: 10 kHz clock model (10 cycles per ms),
// 5 ms slice. Expected grant/led/busy values and pulse durations are queued
// when stimulus is applied and popped when the DUT response is sampled.
module tb_led_blink_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] req;
  logic [7:0] mode;
  logic [3:0] grant;
  logic       led;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [3:0] grant;
    logic       led;
    logic       busy;
  } exp_t;

  exp_t       exp_q[$];
  int         dur_q[$];
  logic       lvl_q[$];
  logic [3:0] seq_q[$];

  led_blink_arbiter #(
    .CLK_FREQ(10_000),
    .NUM_REQ (4),
    .SLICE_MS(5),
    .SLOW_HZ (2),
    .FAST_HZ (8)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .req  (req),
    .mode (mode),
    .grant(grant),
    .led  (led),
    .busy (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    RST_N = 1'b0;
    req   = 4'b1111;
    mode  = 8'b01_01_01_01;
    repeat (3) exp_q.push_back('{"reset_hold", 4'b0000, 1'b0, 1'b0});
    repeat (3) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
        n_fail++;
        $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
                 e.name, grant, led, busy, e.grant, e.led, e.busy);
      end
    end
    RST_N = 1'b1;
    exp_q.push_back('{"reset_first_grant", 4'b0001, 1'b1, 1'b1});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
    req = 4'b0000;
    exp_q.push_back('{"reset_idle", 4'b0000, 1'b0, 1'b0});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
  endtask

  task automatic test_blink();
    exp_t e;
    int   n;
    int   want;
    logic lvl;
    mode = 8'b01_01_10_01;
    req  = 4'b0010;
    exp_q.push_back('{"blink_grant", 4'b0010, 1'b1, 1'b1});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
    // First high phase starts at an arbitrary prescaler offset.
    n = 1;
    step();
    while (led === 1'b1 && n < 6000) begin
      n++;
      step();
    end
    n_checks++;
    if (n < 2491 || n > 2500) begin
      n_fail++;
      $display("FAIL blink_first_high: got %0d cycles want 2491..2500", n);
    end
    lvl_q.push_back(1'b0); dur_q.push_back(2500);
    lvl_q.push_back(1'b1); dur_q.push_back(2500);
    lvl_q.push_back(1'b0); dur_q.push_back(2500);
    while (dur_q.size() > 0) begin
      lvl  = lvl_q.pop_front();
      want = dur_q.pop_front();
      n = 1;
      step();
      while (led === lvl && n < 6000) begin
        n++;
        step();
      end
      n_checks++;
      if (n !== want) begin
        n_fail++;
        $display("FAIL blink_slow_%0d: got %0d cycles want %0d", lvl, n, want);
      end
    end
    // Just after a rising edge: switch to fast blink mid-grant.
    mode = 8'b01_01_11_01;
    lvl_q.push_back(1'b1); dur_q.push_back(620);
    lvl_q.push_back(1'b0); dur_q.push_back(620);
    while (dur_q.size() > 0) begin
      lvl  = lvl_q.pop_front();
      want = dur_q.pop_front();
      n = 1;
      step();
      while (led === lvl && n < 6000) begin
        n++;
        step();
      end
      n_checks++;
      if (n !== want) begin
        n_fail++;
        $display("FAIL blink_fast_%0d: got %0d cycles want %0d", lvl, n, want);
      end
    end
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL blink_owner_kept: got grant=%b want 0010", grant);
    end
    req = 4'b0000;
    exp_q.push_back('{"blink_release", 4'b0000, 1'b0, 1'b0});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] g;
    logic [3:0] want;
    int         n;
    int         bad;
    mode = 8'b01_01_01_01;
    req  = 4'b0011;
    seq_q = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
    step();
    want = seq_q.pop_front();
    n_checks++;
    if (grant !== want) begin
      n_fail++;
      $display("FAIL rot_first: got grant=%b want %b", grant, want);
    end
    while (seq_q.size() > 0) begin
      g = grant;
      n = 1;
      step();
      while (grant === g && n < 200) begin
        n++;
        step();
      end
      n_checks++;
      if (n < 40 || n > 60) begin
        n_fail++;
        $display("FAIL rot_hold: got %0d cycles want 40..60", n);
      end
      want = seq_q.pop_front();
      n_checks++;
      if (grant !== want || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rot_next: got grant=%b busy=%b want grant=%b busy=1", grant, busy, want);
      end
    end
    req = 4'b0001;
    bad = 0;
    repeat (1100) begin
      step();
      if (grant !== 4'b0001) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rot_single_keeps: got %0d cycles without grant 0001 want 0", bad);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_release();
    exp_t e;
    int   bad;
    mode = 8'b00_01_01_01;
    req  = 4'b0100;
    exp_q.push_back('{"rel_grant2", 4'b0100, 1'b1, 1'b1});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
    bad = 0;
    repeat (5) begin
      step();
      if (busy !== 1'b1 || grant !== 4'b0100) bad++;
    end
    req = 4'b1100;
    repeat (5) begin
      step();
      if (busy !== 1'b1 || grant !== 4'b0100) bad++;
    end
    req = 4'b1000;
    exp_q.push_back('{"rel_handoff3_off", 4'b1000, 1'b0, 1'b1});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rel_busy_steady: got %0d bad cycles want 0", bad);
    end
    req = 4'b0000;
    exp_q.push_back('{"rel_all_drop", 4'b0000, 1'b0, 1'b0});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int   n;
    int   bad;
    mode = 8'b01_01_01_01;
    req  = 4'b0101;
    exp_q.push_back('{"sim_first", 4'b0001, 1'b1, 1'b1});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
    n = 0;
    while (grant === 4'b0001 && n < 100) begin
      n++;
      step();
    end
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL sim_rotate: got grant=%b want 0100", grant);
    end
    // Slice ticks now land 9, 19, ... 49 cycles after this rotation, so the
    // slice expires on the 50th edge; drop the owner on that same edge.
    bad = 0;
    repeat (49) begin
      step();
      if (grant !== 4'b0100 || busy !== 1'b1) bad++;
    end
    req = 4'b0001;
    exp_q.push_back('{"sim_drop_expiry", 4'b0001, 1'b1, 1'b1});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
    repeat (100) begin
      step();
      if (grant !== 4'b0001 || busy !== 1'b1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL sim_no_glitch: got %0d bad cycles want 0", bad);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_preempt();
    exp_t e;
    int   n;
    int   bad;
    mode = 8'b01_10_01_01;
    req  = 4'b0100;
    exp_q.push_back('{"pre_owner2", 4'b0100, 1'b1, 1'b1});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
    repeat (10) step();
    req = 4'b0101;
`ifdef LED_ARB_PREEMPT_EN
    exp_q.push_back('{"pre_take0", 4'b0001, 1'b1, 1'b1});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
    bad = 0;
    repeat (100) begin
      step();
      if (grant !== 4'b0001) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL pre_no_rotate: got %0d bad cycles want 0", bad);
    end
    req = 4'b0100;
    exp_q.push_back('{"pre_resume2", 4'b0100, 1'b1, 1'b1});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
    n = 0;
`else
    exp_q.push_back('{"nopre_keep2", 4'b0100, 1'b1, 1'b1});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
    n = 1;
    while (grant === 4'b0100 && n < 60) begin
      n++;
      step();
    end
    n_checks++;
    if (grant !== 4'b0001 || n < 25) begin
      n_fail++;
      $display("FAIL nopre_rotate: got grant=%b after %0d cycles want 0001 after slice", grant, n);
    end
    bad = 0;
`endif
    req = 4'b0000;
    exp_q.push_back('{"pre_idle", 4'b0000, 1'b0, 1'b0});
    step();
    e = exp_q.pop_front();
    n_checks++;
    if ({grant, led, busy} !== {e.grant, e.led, e.busy}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b busy=%b want grant=%b led=%b busy=%b",
               e.name, grant, led, busy, e.grant, e.led, e.busy);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    req   = 4'b0000;
    mode  = 8'b0;
    test_reset();
    test_blink();
    test_rotation();
    test_release();
    test_simultaneous();
    test_preempt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
